// File: rtl/camera_tracker.sv
// Camera controller: turns player_y into a displayed level index and plays a
// one-level scroll animation, moving the outputs only on frame_tick.
module camera_tracker #(
    parameter int PHY_WIDTH    = 16,
    parameter int CAMERA_WIDTH = 6,
    parameter int MAP_HEIGHT   = 470,
    parameter int SCROLL_STEP  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic [PHY_WIDTH-1:0]    player_y,
    output logic [CAMERA_WIDTH-1:0] camera_y,
    output logic [PHY_WIDTH-1:0]    camera_offset,
    output logic                    scrolling
);

    localparam logic [CAMERA_WIDTH-1:0] MAX_LEVEL  = '1;
    localparam logic [CAMERA_WIDTH-1:0] ONE_LEVEL  = CAMERA_WIDTH'(1);
    localparam logic [PHY_WIDTH-1:0]    HEIGHT     = PHY_WIDTH'(MAP_HEIGHT);
    localparam logic [PHY_WIDTH-1:0]    STEP       = PHY_WIDTH'(SCROLL_STEP);
    localparam logic [PHY_WIDTH-1:0]    TOP_OFFSET = PHY_WIDTH'(MAP_HEIGHT - SCROLL_STEP);

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        DECIDE,
        SCROLL_UP,
        SCROLL_DOWN
    } state_t;

    state_t                  state, state_nxt;
    logic [PHY_WIDTH-1:0]    rem, rem_nxt;
    logic [CAMERA_WIDTH-1:0] q, q_nxt;
    logic                    first, first_nxt;
    logic [CAMERA_WIDTH-1:0] camera_y_nxt;
    logic [PHY_WIDTH-1:0]    camera_offset_nxt;
    logic                    scrolling_nxt;
    logic [PHY_WIDTH:0]      offset_up;

    // One extra bit so offset + step can never wrap.
    assign offset_up = {1'b0, camera_offset} + {1'b0, STEP};

    always_comb begin
        state_nxt         = state;
        rem_nxt           = rem;
        q_nxt             = q;
        first_nxt         = first;
        camera_y_nxt      = camera_y;
        camera_offset_nxt = camera_offset;
        scrolling_nxt     = scrolling;

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    rem_nxt   = player_y;
                    q_nxt     = '0;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (rem >= HEIGHT && q != MAX_LEVEL) begin
                    rem_nxt = rem - HEIGHT;
                    q_nxt   = q + ONE_LEVEL;
                end else begin
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                if (q > camera_y) begin
                    state_nxt     = SCROLL_UP;
                    scrolling_nxt = 1'b1;
                end else if (q < camera_y) begin
                    state_nxt     = SCROLL_DOWN;
                    scrolling_nxt = 1'b1;
                    first_nxt     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SCROLL_UP: begin
                if (frame_tick) begin
                    if (offset_up >= {1'b0, HEIGHT}) begin
                        camera_y_nxt      = camera_y + ONE_LEVEL;
                        camera_offset_nxt = '0;
                        scrolling_nxt     = 1'b0;
                        state_nxt         = IDLE;
                    end else begin
                        camera_offset_nxt = offset_up[PHY_WIDTH-1:0];
                    end
                end
            end
            SCROLL_DOWN: begin
                // Offset is 0 on entry, so the flag marks the level-drop tick.
                if (frame_tick) begin
                    if (first) begin
                        camera_y_nxt      = camera_y - ONE_LEVEL;
                        camera_offset_nxt = TOP_OFFSET;
                        first_nxt         = 1'b0;
                    end else if (camera_offset <= STEP) begin
                        camera_offset_nxt = '0;
                        scrolling_nxt     = 1'b0;
                        state_nxt         = IDLE;
                    end else begin
                        camera_offset_nxt = camera_offset - STEP;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rem           <= '0;
            q             <= '0;
            first         <= 1'b0;
            camera_y      <= '0;
            camera_offset <= '0;
            scrolling     <= 1'b0;
        end else begin
            state         <= state_nxt;
            rem           <= rem_nxt;
            q             <= q_nxt;
            first         <= first_nxt;
            camera_y      <= camera_y_nxt;
            camera_offset <= camera_offset_nxt;
            scrolling     <= scrolling_nxt;
        end
    end

endmodule

// File: tb/tb_camera_tracker.sv
// Scoreboard bench for camera_tracker: a per-tick level/scroll model queues the
// expected outputs, and a monitor compares them on every frame_tick edge.
module tb_camera_tracker;

    localparam int H    = 470;
    localparam int S    = 10;
    localparam int NT   = H / S;
    localparam int MAXL = 63;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [15:0] player_y = '0;
    logic [5:0]  camera_y;
    logic [15:0] camera_offset;
    logic        scrolling;

    always #5 clk = ~clk;

    camera_tracker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .player_y      (player_y),
        .camera_y      (camera_y),
        .camera_offset (camera_offset),
        .scrolling     (scrolling)
    );

    typedef struct {
        logic pre;
        int   cy;
        int   off;
        logic post;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: displayed level, offset, scroll direction (0 = at rest) and ticks into the scroll.
    int m_cy  = 0;
    int m_off = 0;
    int m_dir = 0;
    int m_k   = 0;

    function automatic int level_of(input int py);
        int l;
        l = py / H;
        if (l > MAXL) l = MAXL;
        return l;
    endfunction

    task automatic tick_model(input int py);
        exp_t e;
        int   tgt;
        e.pre = (m_dir != 0);
        if (m_dir == 0) begin
            tgt = level_of(py);
            if (tgt > m_cy) m_dir = 1;
            else if (tgt < m_cy) m_dir = -1;
            m_k = 0;
        end else begin
            m_k++;
            if (m_dir == 1) begin
                if (m_k == NT) begin
                    m_cy++;
                    m_off = 0;
                    m_dir = 0;
                end else begin
                    m_off = m_k * S;
                end
            end else begin
                if (m_k == 1) m_cy--;
                if (m_k == NT) begin
                    m_off = 0;
                    m_dir = 0;
                end else begin
                    m_off = H - S * m_k;
                end
            end
        end
        e.post = (m_dir != 0) && (e.pre != 0);
        e.cy   = m_cy;
        e.off  = m_off;
        exp_q.push_back(e);
    endtask

    task automatic pulse();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic step();
        logic was_idle;
        was_idle = (m_dir == 0);
        tick_model(int'(player_y));
        pulse();
        if (was_idle) repeat (150) @(posedge clk);
        else repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic run_pass();
        step();
        for (int n = 0; n < 60 && m_dir != 0; n++) step();
    endtask

    task automatic settle();
        for (int n = 0; n < 80 && level_of(int'(player_y)) != m_cy; n++) run_pass();
    endtask

    task automatic check_zero(input string name);
        total++;
        if (camera_y !== 6'd0 || camera_offset !== 16'd0 || scrolling !== 1'b0) begin
            bad++;
            $display("FAIL %s: got cy=%0d off=%0d scr=%0b, want 0/0/0",
                     name, camera_y, camera_offset, scrolling);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        m_cy = 0; m_off = 0; m_dir = 0; m_k = 0;
    endtask

    // Monitor: pre-edge values are latched on the falling edge.
    logic       scr_prev;
    logic [5:0] cy_prev;
    logic [15:0] off_prev;
    always @(negedge clk) begin
        scr_prev = scrolling;
        cy_prev  = camera_y;
        off_prev = camera_offset;
    end

    logic mon_tick, mon_rst, mon_pre;
    logic [5:0]  mon_cy;
    logic [15:0] mon_off;
    exp_t        mon_e;
    initial begin
        forever begin
            @(posedge clk);
            mon_tick = frame_tick;
            mon_rst  = rst_n;
            mon_pre  = scr_prev;
            mon_cy   = cy_prev;
            mon_off  = off_prev;
            #1;
            if (mon_rst && mon_tick) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tick_unexpected: got cy=%0d off=%0d, no expectation queued",
                             camera_y, camera_offset);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_pre !== mon_e.pre || camera_y !== 6'(mon_e.cy) ||
                        camera_offset !== 16'(mon_e.off) || scrolling !== mon_e.post) begin
                        bad++;
                        $display("FAIL tick: got pre=%0b cy=%0d off=%0d scr=%0b, want pre=%0b cy=%0d off=%0d scr=%0b",
                                 mon_pre, camera_y, camera_offset, scrolling,
                                 mon_e.pre, mon_e.cy, mon_e.off, mon_e.post);
                    end
                end
            end else if (mon_rst) begin
                total++;
                if (camera_y !== mon_cy || camera_offset !== mon_off) begin
                    bad++;
                    $display("FAIL stable: got cy=%0d off=%0d, want unchanged cy=%0d off=%0d",
                             camera_y, camera_offset, mon_cy, mon_off);
                end
            end
        end
    end

    exp_t stray;
    initial begin
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        repeat (2) @(posedge clk);
        #1;

        player_y = 16'd100;
        run_pass();
        player_y = 16'd500;
        run_pass();
        player_y = 16'd300;
        run_pass();
        player_y = 16'd1500;
        settle();

        // Stray ticks and a toggled player_y while the divider is busy.
        player_y = 16'(H * 8 + 7);
        step_with_stray();
        player_y = ~16'(H * 8 + 7);
        settle();
        player_y = 16'd65535;
        run_pass();

        do_reset();
        player_y = 16'd500;
        step();
        for (int i = 0; i < 23; i++) step();
        do_reset();
        run_pass();

        for (int i = 0; i < 30; i++) begin
            player_y = 16'($urandom_range(0, H * 4 - 1));
            settle();
        end

        repeat (5) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d queued expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic step_with_stray();
        tick_model(int'(player_y));
        pulse();
        repeat (2) @(posedge clk);
        #1;
        player_y = ~player_y;
        stray.pre  = 1'b0;
        stray.cy   = m_cy;
        stray.off  = m_off;
        stray.post = 1'b0;
        exp_q.push_back(stray);
        pulse();
        repeat (150) @(posedge clk);
        #1;
        for (int n = 0; n < 60 && m_dir != 0; n++) step();
    endtask

endmodule
